bram_port_master: RTL
=====================

# bram_port_master

Request/response front end that drives the single port of the team's block RAM (`bram`: clock, ram_enable, write_enable, address, input_data, output_data; one-cycle registered read). Converts a valid/ready request stream into registered BRAM port cycles and returns read data in order through a valid/ready response stream with backpressure. Also contains an init engine that fills a fixed address range with a constant, so client logic never drives the RAM port directly.

## Interface
Parameters:
- RAM_WIDTH, 32, data width; must match the attached bram.
- RAM_ADDR_BITS, 9, address width; must match the attached bram.
- INIT_START_ADDR, 0, first address written by the init engine.
- INIT_END_ADDR, 10, last address written, inclusive. Legal only if INIT_START_ADDR <= INIT_END_ADDR < 2**RAM_ADDR_BITS.
- INIT_VALUE, 0, RAM_WIDTH-bit word written during init.

Ports:
- clock  in  1  single clock for all logic, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where valid and ready are both high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  RAM_ADDR_BITS  request address.
- req_wdata  in  RAM_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes rsp_data on an edge where valid and ready are both high.
- rsp_data  out  RAM_WIDTH  read data, in request order.
- init_start  in  1  single-cycle init request.
- init_busy  out  1  high in DRAIN and INIT.
- init_done  out  1  one-cycle pulse after the last init write is issued.
- ram_enable, write_enable  out  1 each  to bram; registered.
- address  out  RAM_ADDR_BITS  to bram; registered.
- input_data  out  RAM_WIDTH  to bram; registered.
- output_data  in  RAM_WIDTH  from bram.

## Operation
- States: SERVE, DRAIN, INIT.
- SERVE:
  - req_ready = (fifo_count + s1_rd + s2_rd) < 4. Writes are gated by the same condition.
  - Each accepted request registers ram_enable=1, write_enable=req_write, address=req_addr and input_data=req_wdata for exactly one cycle.
  - When no request is accepted, ram_enable and write_enable are 0.
- Read pipeline:
  - s1_rd marks a read on the port this cycle.
  - s2_rd marks that output_data holds its result this cycle.
  - When s2_rd is set, output_data is pushed into a 4-entry response FIFO.
  - output_data on write cycles is never captured.
- Response FIFO: rsp_valid = !empty; rsp_data = head. Push and pop in the same cycle are both allowed. The credit rule means it never overflows.
- SERVE -> DRAIN: init_start sampled high. req_ready goes to 0 from the next cycle. init_start is ignored in DRAIN and INIT.
- DRAIN -> INIT: when s1_rd = s2_rd = 0. The FIFO may still hold responses; they continue to drain.
- INIT:
  - Issues one write per cycle: address counts INIT_START_ADDR..INIT_END_ADDR, data INIT_VALUE.
  - Ignores rsp-side stalls.
  - After the last write is registered, init_done pulses and the state returns to SERVE.
  - Total writes = INIT_END_ADDR - INIT_START_ADDR + 1.
- Reset:
  - State SERVE; FIFO empty; s1/s2 cleared. In-flight reads are discarded.
  - req_ready = 1 from the first cycle after reset.
  - rsp_valid, init_busy, init_done, ram_enable, write_enable, address, input_data all 0.
  - BRAM contents are untouched.
  - Reset during INIT aborts the fill with no init_done.

## Timing
- Acceptance edge E0: port signals are valid between E0 and E1. bram samples at E1. output_data is valid between E1 and E2. FIFO push at E2.
- rsp_valid is high from E2 if the FIFO was empty: read latency is 2 cycles.
- Full throughput of 1 request/cycle is sustained while rsp_ready = 1.
- Write at E0 followed by a read of the same address at E0+1 returns the new data.
- With rsp_ready = 0, at most 4 reads are outstanding. req_ready drops in the same cycle the count reaches 4.
- INIT of N words: init_busy is high from the edge after init_start through the cycle of the init_done pulse. The init_done pulse comes 1 cycle after the Nth write is presented on the port.

## Test plan
- Write 0xDEADBEEF to addr 5, then read addr 5 back-to-back -> rsp_data = 0xDEADBEEF, rsp_valid 2 cycles after the read is accepted.
- Reads of addrs 0..7 on consecutive cycles with rsp_ready = 1 -> req_ready stays 1; 8 responses on consecutive cycles, in order.
- rsp_ready = 0, 6 reads offered -> exactly 4 accepted, req_ready = 0 until pops. Release -> 4 responses in order, then the remaining 2 are accepted.
- Defaults, init_start with 2 reads in flight:
  - the 2 reads complete;
  - writes to addrs 0..10 with value 0 follow;
  - init_done pulses once after 11 writes;
  - reads of 0..10 return 0 and addr 11 keeps its prior value.
- reset asserted mid-INIT (after 4 writes) -> all outputs 0 the next cycle, no init_done, req_ready = 1 after reset deasserts. The FIFO is empty.
- init_start pulsed during INIT -> ignored; exactly one init_done.

Source files
------------

// File: rtl/bram_port_master.sv
// Valid/ready front end for a single-port BRAM: in-order read return through a 4-deep
// response FIFO, plus an init engine that fills a fixed address range with a constant.

module bram_port_master #(
  parameter int unsigned          RAM_WIDTH       = 32,
  parameter int unsigned          RAM_ADDR_BITS   = 9,
  parameter int unsigned          INIT_START_ADDR = 0,
  parameter int unsigned          INIT_END_ADDR   = 10,
  parameter logic [RAM_WIDTH-1:0] INIT_VALUE      = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [RAM_ADDR_BITS-1:0] req_addr,
  input  logic [RAM_WIDTH-1:0]     req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [RAM_WIDTH-1:0]     rsp_data,
  input  logic                     init_start,
  output logic                     init_busy,
  output logic                     init_done,
  output logic                     ram_enable,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] address,
  output logic [RAM_WIDTH-1:0]     input_data,
  input  logic [RAM_WIDTH-1:0]     output_data
);

  typedef enum logic [1:0] {StServe, StDrain, StInit} state_e;

  localparam logic [RAM_ADDR_BITS-1:0] InitFirst = RAM_ADDR_BITS'(INIT_START_ADDR);
  localparam logic [RAM_ADDR_BITS-1:0] InitLast  = RAM_ADDR_BITS'(INIT_END_ADDR);

  state_e                   state_q, state_d;
  logic                     s1_rd_q, s1_rd_d, s2_rd_q;
  logic [RAM_ADDR_BITS-1:0] init_addr_q, init_addr_d;
  logic                     init_issued_q, init_issued_d;
  logic                     init_done_q, init_done_d;
  logic                     ram_enable_d, write_enable_d;
  logic [RAM_ADDR_BITS-1:0] address_d;
  logic [RAM_WIDTH-1:0]     input_data_d;

  logic [RAM_WIDTH-1:0]     fifo_q [4];
  logic [1:0]               wr_ptr_q, rd_ptr_q;
  logic [2:0]               count_q, credit;
  logic                     push, pop, req_fire;

  // Credit counts FIFO entries plus reads still in the BRAM pipeline, so the FIFO never overflows.
  always_comb begin
    credit    = count_q + {2'b00, s1_rd_q} + {2'b00, s2_rd_q};
    req_ready = (state_q == StServe) && (credit < 3'd4);
    req_fire  = req_valid && req_ready;
    push      = s2_rd_q;
    rsp_valid = (count_q != 3'd0);
    pop       = rsp_valid && rsp_ready;
    rsp_data  = fifo_q[rd_ptr_q];
    init_busy = (state_q != StServe);
    init_done = init_done_q;
  end

  always_comb begin
    state_d        = state_q;
    s1_rd_d        = 1'b0;
    ram_enable_d   = 1'b0;
    write_enable_d = 1'b0;
    address_d      = address;
    input_data_d   = input_data;
    init_addr_d    = init_addr_q;
    init_issued_d  = init_issued_q;
    init_done_d    = 1'b0;
    case (state_q)
      StServe: begin
        if (req_fire) begin
          ram_enable_d   = 1'b1;
          write_enable_d = req_write;
          address_d      = req_addr;
          input_data_d   = req_wdata;
          s1_rd_d        = !req_write;
        end
        if (init_start) state_d = StDrain;
      end
      StDrain: begin
        if (!s1_rd_q && !s2_rd_q) begin
          state_d       = StInit;
          init_addr_d   = InitFirst;
          init_issued_d = 1'b0;
        end
      end
      StInit: begin
        // Phases: issue writes, then one cycle of init_done, then back to serving.
        if (!init_issued_q) begin
          ram_enable_d   = 1'b1;
          write_enable_d = 1'b1;
          address_d      = init_addr_q;
          input_data_d   = INIT_VALUE;
          if (init_addr_q == InitLast) init_issued_d = 1'b1;
          else                         init_addr_d   = init_addr_q + RAM_ADDR_BITS'(1);
        end else if (!init_done_q) begin
          init_done_d = 1'b1;
        end else begin
          state_d       = StServe;
          init_issued_d = 1'b0;
        end
      end
      default: state_d = StServe;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StServe;
      s1_rd_q       <= 1'b0;
      s2_rd_q       <= 1'b0;
      init_addr_q   <= InitFirst;
      init_issued_q <= 1'b0;
      init_done_q   <= 1'b0;
      ram_enable    <= 1'b0;
      write_enable  <= 1'b0;
      address       <= '0;
      input_data    <= '0;
      wr_ptr_q      <= 2'd0;
      rd_ptr_q      <= 2'd0;
      count_q       <= 3'd0;
    end else begin
      state_q       <= state_d;
      s1_rd_q       <= s1_rd_d;
      s2_rd_q       <= s1_rd_q;
      init_addr_q   <= init_addr_d;
      init_issued_q <= init_issued_d;
      init_done_q   <= init_done_d;
      ram_enable    <= ram_enable_d;
      write_enable  <= write_enable_d;
      address       <= address_d;
      input_data    <= input_data_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= output_data;
  end

endmodule
